// File: rtl/mm_cmd_master.sv
// Command-channel master: sends a header, one computation command per block, collects
// one checksum response per block, then issues the terminate command (word 0).
module mm_cmd_master #(
    parameter int unsigned W_D      = 32,
    parameter int unsigned W_COMM_A = 4
) (
    input  logic           CLK,
    input  logic           RST_X,
    input  logic           start,
    input  logic [W_D-1:0] matrix_size,
    input  logic [W_D-1:0] block_size,
    input  logic [W_D-1:0] num_blocks,
    output logic [W_D-1:0] cmd_d,
    output logic           cmd_enq,
    input  logic           cmd_full,
    input  logic [W_D-1:0] rsp_q,
    output logic           rsp_deq,
    input  logic           rsp_empty,
    output logic           busy,
    output logic           done,
    output logic [W_D-1:0] total_sum,
    output logic [W_D-1:0] last_latency
);

    // The channel depth exponent only documents the FIFOs this master is paired with.
    if (W_COMM_A > 31) begin : g_depth_note
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BLK,
        S_RWAIT,
        S_RDEQ,
        S_RCAP,
        S_TERM,
        S_FIN
    } state_e;

    state_e         state_q;
    logic [W_D-1:0] msize_q;
    logic [W_D-1:0] bsize_q;
    logic [W_D-1:0] nblk_q;
    logic [W_D-1:0] blk_cnt_q;
    logic [W_D-1:0] lat_q;
    logic [W_D-1:0] cmd_d_q;
    logic [W_D-1:0] sum_q;
    logic [W_D-1:0] last_lat_q;
    logic           cmd_enq_q;
    logic           rsp_deq_q;
    logic           busy_q;
    logic           done_q;

    logic [W_D-1:0] blk_cnt_inc_c;
    logic [W_D-1:0] lat_inc_c;

    assign blk_cnt_inc_c = blk_cnt_q + W_D'(1);
    assign lat_inc_c     = (&lat_q) ? lat_q : lat_q + W_D'(1);

    // rsp_deq is registered: emptiness seen in RWAIT drives the dequeue during RDEQ.
    // This master is the only consumer, so the entry it saw cannot vanish in between,
    // and the read data is on rsp_q by RCAP.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= S_IDLE;
            msize_q    <= '0;
            bsize_q    <= '0;
            nblk_q     <= '0;
            blk_cnt_q  <= '0;
            lat_q      <= '0;
            cmd_d_q    <= '0;
            sum_q      <= '0;
            last_lat_q <= '0;
            cmd_enq_q  <= 1'b0;
            rsp_deq_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cmd_enq_q <= 1'b0;
            rsp_deq_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        msize_q   <= matrix_size;
                        bsize_q   <= block_size;
                        nblk_q    <= num_blocks;
                        sum_q     <= '0;
                        blk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!cmd_full) begin
                        cmd_d_q   <= msize_q;
                        cmd_enq_q <= 1'b1;
                        state_q   <= (nblk_q != '0) ? S_BLK : S_TERM;
                    end
                end
                S_BLK: begin
                    if (!cmd_full) begin
                        cmd_d_q   <= bsize_q;
                        cmd_enq_q <= 1'b1;
                        lat_q     <= '0;
                        state_q   <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    lat_q <= lat_inc_c;
                    if (!rsp_empty) begin
                        rsp_deq_q <= 1'b1;
                        state_q   <= S_RDEQ;
                    end
                end
                S_RDEQ: begin
                    state_q <= S_RCAP;
                end
                S_RCAP: begin
                    sum_q      <= sum_q + rsp_q;
                    last_lat_q <= lat_q;
                    blk_cnt_q  <= blk_cnt_inc_c;
                    state_q    <= (blk_cnt_inc_c == nblk_q) ? S_TERM : S_BLK;
                end
                S_TERM: begin
                    if (!cmd_full) begin
                        cmd_d_q   <= '0;
                        cmd_enq_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_d        = cmd_d_q;
    assign cmd_enq      = cmd_enq_q;
    assign rsp_deq      = rsp_deq_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign total_sum    = sum_q;
    assign last_latency = last_lat_q;

endmodule
